// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the serial command path (frame collector and decoder).
package serial_cmd_pkg;

  // Collector FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StReady,
    StAck,
    StFlush
  } collect_state_e;

  // Frame delimiters: SOF SOF SPACE LEN payload EOF EOF.
  localparam logic [7:0] SOF_BYTE   = 8'hFF;
  localparam logic [7:0] SPACE_BYTE = 8'h00;
  localparam logic [7:0] EOF_BYTE   = 8'hEE;

  localparam int unsigned HEADER_BYTES  = 4;
  localparam int unsigned TRAILER_BYTES = 2;

  // Zero-based position of the LEN byte within a frame.
  localparam int unsigned LEN_INDEX = HEADER_BYTES - 1;

  // Total frame length implied by LEN; 9 bits so LEN=255 cannot wrap.
  function automatic logic [8:0] frame_total_len(logic [7:0] len);
    return 9'(HEADER_BYTES) + {1'b0, len} + 9'(TRAILER_BYTES);
  endfunction

endpackage

// File: rtl/serial_idle_timer.sv
// Inter-byte silence timer: pulses expired_o on the TimeoutClks-th clock edge
// after the most recent restart, provided counting stayed enabled.
module serial_idle_timer #(
  parameter int unsigned TimeoutClks = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TimeoutClks + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count clock edges since the last restart; the restart edge itself is the first.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = CntW'(1);
    end else if (enable_i && (cnt_q != CntW'(TimeoutClks))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving in the same cycle wins over the expiry.
  assign expired_o = enable_i && !restart_i && (cnt_q == CntW'(TimeoutClks - 1));

endmodule

// File: rtl/serial_cmd_frame_collector.sv
// Frame collector: pushes UART bytes into the shared fifo, tracks the frame
// length from its header and hands complete or aborted frames to the decoder.
module serial_cmd_frame_collector
  import serial_cmd_pkg::*;
#(
  parameter int unsigned MaxFrameBytes   = 16,
  parameter int unsigned IdleTimeoutClks = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       fifo_full_i,
  input  logic       cmd_processed_i,
  output logic       fifo_push_o,
  output logic [7:0] fifo_data_o,
  output logic       fifo_clear_o,
  output logic       cmd_ready_o,
  output logic       cmd_processed_received_o,
  output logic       frame_truncated_o,
  output logic       overrun_o,
  output logic [7:0] frame_bytes_o
);

  collect_state_e state_q, state_d;

  logic       push_q, push_d;
  logic [7:0] data_q, data_d;
  logic [7:0] frame_bytes_q, frame_bytes_d;
  logic [7:0] len_q, len_d;
  logic       len_valid_q, len_valid_d;
  logic       trunc_q, trunc_d;
  logic       overrun_q, overrun_d;

  logic       timer_expired;
  logic [8:0] total_raw;
  logic [8:0] total_sat;
  logic       end_len, end_cap, end_timeout, frame_end;
  logic       accept, drop;

  serial_idle_timer #(
    .TimeoutClks(IdleTimeoutClks)
  ) u_idle_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .restart_i(rx_valid_i),
    .enable_i (state_q == StCollect),
    .expired_o(timer_expired)
  );

  // Frame-end detection and byte acceptance for the current cycle.
  always_comb begin
    total_raw = frame_total_len(len_q);
    total_sat = (total_raw > 9'(MaxFrameBytes)) ? 9'(MaxFrameBytes) : total_raw;
    // A LEN that overflows the cap must end as truncated, so require it to fit.
    end_len     = len_valid_q && (total_raw <= 9'(MaxFrameBytes)) &&
                  ({1'b0, frame_bytes_q} == total_sat);
    end_cap     = (frame_bytes_q == 8'(MaxFrameBytes));
    end_timeout = timer_expired && (frame_bytes_q != 8'd0);
    frame_end   = (state_q == StCollect) && (end_len || end_cap || end_timeout);
    // Bytes coinciding with the frame end are dropped.
    accept      = rx_valid_i && !fifo_full_i &&
                  ((state_q == StIdle) || ((state_q == StCollect) && !frame_end));
    drop        = rx_valid_i && !accept;
  end

  // Datapath next-state: push pipeline, byte count, LEN capture, status flags.
  always_comb begin
    push_d        = accept;
    data_d        = accept ? rx_data_i : data_q;
    frame_bytes_d = frame_bytes_q;
    len_d         = len_q;
    len_valid_d   = len_valid_q;
    trunc_d       = trunc_q;
    overrun_d     = overrun_q;

    if (accept) begin
      frame_bytes_d = frame_bytes_q + 8'd1;
      if (frame_bytes_q == 8'(LEN_INDEX)) begin
        len_d       = rx_data_i;
        len_valid_d = 1'b1;
      end
    end

    if (frame_end) begin
      trunc_d = !end_len;
    end

    if (state_q == StFlush) begin
      frame_bytes_d = 8'd0;
      len_d         = 8'd0;
      len_valid_d   = 1'b0;
      trunc_d       = 1'b0;
      overrun_d     = 1'b0;
    end

    // A drop in the flush cycle still gets reported.
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_q        <= 1'b0;
      data_q        <= 8'd0;
      frame_bytes_q <= 8'd0;
      len_q         <= 8'd0;
      len_valid_q   <= 1'b0;
      trunc_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      push_q        <= push_d;
      data_q        <= data_d;
      frame_bytes_q <= frame_bytes_d;
      len_q         <= len_d;
      len_valid_q   <= len_valid_d;
      trunc_q       <= trunc_d;
      overrun_q     <= overrun_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rx_valid_i) state_d = StCollect;
      end
      StCollect: begin
        if (frame_end) begin
          state_d = StReady;
        end else if (timer_expired) begin
          // Every byte was dropped; nothing to hand over.
          state_d = StIdle;
        end
      end
      StReady: begin
        if (cmd_processed_i) state_d = StAck;
      end
      StAck: begin
        if (!cmd_processed_i) state_d = StFlush;
      end
      StFlush: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM outputs and registered datapath outputs.
  always_comb begin
    cmd_ready_o              = (state_q == StReady);
    cmd_processed_received_o = (state_q == StAck);
    fifo_clear_o             = (state_q == StFlush);
    fifo_push_o              = push_q;
    fifo_data_o              = data_q;
    frame_truncated_o        = trunc_q;
    overrun_o                = overrun_q;
    frame_bytes_o            = frame_bytes_q;
  end

endmodule

// File: tb/tb_serial_cmd_frame_collector.sv
// Randomized and directed bench for serial_cmd_frame_collector against a
// frame-level reference model.
module tb_serial_cmd_frame_collector;

  localparam int unsigned TO   = 100;
  localparam int unsigned MAXB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic       cmd_processed = 1'b0;
  logic       fifo_push, fifo_clear, cmd_ready, cmd_processed_received;
  logic       frame_truncated, overrun;
  logic [7:0] fifo_data, frame_bytes;

  always #5 clk = ~clk;

  serial_cmd_frame_collector #(
    .MaxFrameBytes  (MAXB),
    .IdleTimeoutClks(TO)
  ) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .rx_data_i               (rx_data),
    .rx_valid_i              (rx_valid),
    .fifo_full_i             (fifo_full),
    .cmd_processed_i         (cmd_processed),
    .fifo_push_o             (fifo_push),
    .fifo_data_o             (fifo_data),
    .fifo_clear_o            (fifo_clear),
    .cmd_ready_o             (cmd_ready),
    .cmd_processed_received_o(cmd_processed_received),
    .frame_truncated_o       (frame_truncated),
    .overrun_o               (overrun),
    .frame_bytes_o           (frame_bytes)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: fifo pushes, clear pulses and cmd_ready rise time.
  logic [7:0] pushed_q[$];
  int cyc = 0;
  int clear_cnt = 0;
  int last_push_cyc = 0;
  int ready_rise_cyc = 0;
  logic ready_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_push) begin
      pushed_q.push_back(fifo_data);
      last_push_cyc <= cyc;
    end
    if (fifo_clear) clear_cnt <= clear_cnt + 1;
    if (cmd_ready && !ready_prev) ready_rise_cyc <= cyc;
    ready_prev <= cmd_ready;
  end

  // Stimulus for one frame: byte, fifo_full at its strobe, cycles since previous strobe.
  logic [7:0] tx_b[$];
  bit         tx_full[$];
  int         tx_gap[$];
  logic [7:0] exp_b[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit full);
    rx_data   = b;
    rx_valid  = 1'b1;
    fifo_full = full;
    step();
    rx_valid  = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic add_byte(input logic [7:0] b, input bit full, input int gap);
    tx_b.push_back(b);
    tx_full.push_back(full);
    tx_gap.push_back(gap);
  endtask

  task automatic clear_tx();
    tx_b.delete();
    tx_full.delete();
    tx_gap.delete();
  endtask

  // Reference: bytes are taken in order unless the fifo is full or the frame has
  // ended; the 4th byte taken is LEN; the frame ends at 6+LEN bytes, else at the
  // cap, else by the silence that follows the stream (truncated).
  task automatic model_frame(output bit trunc, output bit ovr);
    int  len;
    bit  ended;
    len   = -1;
    ended = 1'b0;
    trunc = 1'b1;
    ovr   = 1'b0;
    exp_b.delete();
    for (int i = 0; i < tx_b.size(); i++) begin
      if (ended || tx_full[i]) begin
        ovr = 1'b1;
      end else begin
        exp_b.push_back(tx_b[i]);
        if (exp_b.size() == 4) len = int'(tx_b[i]);
        if (len >= 0 && exp_b.size() == 6 + len) begin
          ended = 1'b1;
          trunc = 1'b0;
        end else if (exp_b.size() == MAXB) begin
          ended = 1'b1;
          trunc = 1'b1;
        end
      end
    end
  endtask

  // Send the queued stream; returns cycles from the last strobe to cmd_ready.
  task automatic run_frame(input string tag, output int k);
    bit trunc, ovr;
    pushed_q.delete();
    for (int i = 0; i < tx_b.size(); i++) begin
      repeat (tx_gap[i] - 1) step();
      send_byte(tx_b[i], tx_full[i]);
    end
    k = 1;
    while (!cmd_ready && k < int'(TO) + 60) begin
      step();
      k++;
    end
    check_eq({tag, "_ready"}, cmd_ready, 1);
    step();
    model_frame(trunc, ovr);
    check_eq({tag, "_npush"}, pushed_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < pushed_q.size(); i++) begin
      check_eq({tag, "_data"}, pushed_q[i], exp_b[i]);
    end
    check_eq({tag, "_fbytes"}, frame_bytes, exp_b.size());
    check_eq({tag, "_trunc"}, frame_truncated, trunc);
    check_eq({tag, "_ovr"}, overrun, ovr);
  endtask

  // Decoder handshake; optionally strobes a byte while READY, which must be dropped.
  task automatic handshake(input string tag, input int hold, input bit extra);
    int clr0, ack, np;
    if (extra) begin
      np = pushed_q.size();
      send_byte(8'h5A, 1'b0);
      step();
      check_eq({tag, "_busy_nopush"}, pushed_q.size(), np);
      check_eq({tag, "_busy_ovr"}, overrun, 1);
    end
    clr0 = clear_cnt;
    ack  = 0;
    cmd_processed = 1'b1;
    repeat (hold) begin
      step();
      if (cmd_processed_received && !cmd_ready) ack++;
    end
    cmd_processed = 1'b0;
    repeat (3) step();
    check_eq({tag, "_ack_cycles"}, ack, hold);
    check_eq({tag, "_clear_pulses"}, clear_cnt - clr0, 1);
    check_eq({tag, "_post_idle"},
             {cmd_ready, cmd_processed_received, frame_truncated, overrun, frame_bytes}, 0);
  endtask

  task automatic load_valid_frame(input int gap);
    logic [7:0] f[12];
    f = '{8'hFF, 8'hFF, 8'h00, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hEE, 8'hEE};
    clear_tx();
    for (int i = 0; i < 12; i++) add_byte(f[i], 1'b0, gap);
  endtask

  initial begin
    int k;
    int len, nb;

    // Reset state.
    repeat (3) step();
    check_eq("reset_outputs", {fifo_push, fifo_data, fifo_clear, cmd_ready,
             cmd_processed_received, frame_truncated, overrun, frame_bytes}, 0);
    rst_n = 1'b1;
    step();

    // Valid frame, 8 clocks apart.
    load_valid_frame(8);
    run_frame("valid", k);
    check_eq("valid_ready_latency", ready_rise_cyc - last_push_cyc, 1);
    handshake("valid_hs", 5, 1'b0);

    // Silence after a partial header.
    clear_tx();
    add_byte(8'hFF, 1'b0, 3);
    add_byte(8'hFF, 1'b0, 3);
    add_byte(8'h00, 1'b0, 3);
    run_frame("timeout", k);
    check_eq("timeout_latency", k, TO);
    handshake("timeout_hs", 2, 1'b0);

    // LEN too large: capped at the fifo depth.
    clear_tx();
    add_byte(8'hFF, 1'b0, 2);
    add_byte(8'hFF, 1'b0, 2);
    add_byte(8'h00, 1'b0, 2);
    add_byte(8'h20, 1'b0, 2);
    for (int i = 0; i < 20; i++) add_byte(8'(8'h30 + i), 1'b0, 2);
    run_frame("cap", k);
    handshake("cap_hs", 3, 1'b0);

    // fifo_full drop in COLLECT, then a drop during READY.
    clear_tx();
    add_byte(8'hFF, 1'b0, 4);
    add_byte(8'hFF, 1'b0, 4);
    add_byte(8'h00, 1'b0, 4);
    add_byte(8'h02, 1'b0, 4);
    add_byte(8'hAA, 1'b1, 4);
    add_byte(8'hBB, 1'b0, 4);
    add_byte(8'hCC, 1'b0, 4);
    add_byte(8'hEE, 1'b0, 4);
    add_byte(8'hEE, 1'b0, 4);
    run_frame("full", k);
    handshake("full_hs", 4, 1'b1);

    // Reset mid-frame, then a clean frame.
    load_valid_frame(3);
    for (int i = 0; i < 5; i++) begin
      repeat (2) step();
      send_byte(tx_b[i], 1'b0);
    end
    #3 rst_n = 1'b0;
    #1;
    check_eq("midreset_outputs", {fifo_push, fifo_data, fifo_clear, cmd_ready,
             cmd_processed_received, frame_truncated, overrun, frame_bytes}, 0);
    step();
    #2 rst_n = 1'b1;
    step();
    run_frame("after_reset", k);
    handshake("after_reset_hs", 1, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(0, 12);
      nb  = $urandom_range(1, 22);
      clear_tx();
      for (int i = 0; i < nb; i++) begin
        logic [7:0] b;
        case (i)
          0, 1:    b = 8'hFF;
          2:       b = 8'h00;
          3:       b = 8'(len);
          default: b = 8'($urandom_range(0, 255));
        endcase
        add_byte(b, (i > 0) && ($urandom_range(0, 7) == 0), $urandom_range(1, 6));
      end
      run_frame("rand", k);
      handshake("rand_hs", $urandom_range(1, 6), $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
